mod_codec_config: RTL

MOD_CODEC_CONFIG -- requirements
Module: mod_codec_config

---
 rtl/mod_codec_config_pkg.sv | 27 ++
 rtl/mod_codec_config_rom.sv | 26 ++
 rtl/mod_codec_config.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mod_codec_config_pkg.sv
// pkg_codec_config: shared FSM states, ROM entry type and WM8731 register map
package pkg_codec_config;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_WAIT_DONE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;
  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } codec_entry_t;
  localparam logic [6:0] WM_LINV   = 7'h00;
  localparam logic [6:0] WM_RINV   = 7'h01;
  localparam logic [6:0] WM_LHPOUT = 7'h02;
  localparam logic [6:0] WM_RHPOUT = 7'h03;
  localparam logic [6:0] WM_APATH  = 7'h04;
  localparam logic [6:0] WM_DPATH  = 7'h05;
  localparam logic [6:0] WM_PWR    = 7'h06;
  localparam logic [6:0] WM_IFACE  = 7'h07;
  localparam logic [6:0] WM_SRATE  = 7'h08;
  localparam logic [6:0] WM_ACTIVE = 7'h09;
  localparam logic [6:0] WM_RESET  = 7'h0F;
endpackage

// File: rtl/mod_codec_config_rom.sv
// mod_codec_config_rom: combinational WM8731 init table lookup
//   i_index  4-bit ROM index
//   o_entry  {register, data}; indices past the table return all zeros
module mod_codec_config_rom
  import pkg_codec_config::*;
(
  input  logic [3:0]   i_index,
  output codec_entry_t o_entry
);
  always_comb begin
    case (i_index)
      4'd0:    o_entry = {WM_RESET,  9'h000};
      4'd1:    o_entry = {WM_LINV,   9'h017};
      4'd2:    o_entry = {WM_RINV,   9'h017};
      4'd3:    o_entry = {WM_LHPOUT, 9'h079};
      4'd4:    o_entry = {WM_RHPOUT, 9'h079};
      4'd5:    o_entry = {WM_APATH,  9'h012};
      4'd6:    o_entry = {WM_DPATH,  9'h000};
      4'd7:    o_entry = {WM_PWR,    9'h000};
      4'd8:    o_entry = {WM_IFACE,  9'h042};
      4'd9:    o_entry = {WM_SRATE,  9'h000};
      4'd10:   o_entry = {WM_ACTIVE, 9'h001};
      default: o_entry = '0;
    endcase
  end
endmodule

// File: rtl/mod_codec_config.sv
// mod_codec_config: sequences the codec init ROM through an I2C master, one reset-pulsed transaction per entry
//   i_clk/i_nrst            clock, async active-low reset
//   i_start                 level request to run the sequence (ignored while busy)
//   o_i2c_addr/register/data/rnw  transaction fields to the I2C master
//   o_i2c_nrst              master reset; each rising edge launches one transaction
//   i_i2c_done/i_i2c_fault  master status (fault 4'hf ok, 4'h0 in progress, else fault)
//   o_busy/o_config_done/o_config_error/o_fail_index  sequence status
//   CODEC_CONFIG_RETRY_EN   when defined, failed entries are retried up to MAX_RETRIES times
module mod_codec_config
  import pkg_codec_config::*;
#(
  parameter logic [6:0] I2C_ADDR           = 7'h1A,
  parameter int         NUM_WRITES         = 11,
  parameter int         RESET_PULSE_CYCLES = 16,
  parameter int         BLANK_CYCLES       = 1024,
  parameter int         TIMEOUT_CYCLES     = 65535,
  parameter int         MAX_RETRIES        = 3
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_start,
  output logic [6:0] o_i2c_addr,
  output logic [6:0] o_i2c_register,
  output logic [8:0] o_i2c_data,
  output logic       o_i2c_rnw,
  output logic       o_i2c_nrst,
  input  logic       i_i2c_done,
  input  logic [3:0] i_i2c_fault,
  output logic       o_busy,
  output logic       o_config_done,
  output logic       o_config_error,
  output logic [3:0] o_fail_index
);
  if (NUM_WRITES < 1 || NUM_WRITES > 16 || RESET_PULSE_CYCLES < 1 || MAX_RETRIES < 0)
    $error("mod_codec_config: parameter out of range");
  localparam logic [16:0] PULSE_LAST   = 17'(RESET_PULSE_CYCLES - 1);
  localparam logic [16:0] BLANK        = 17'(BLANK_CYCLES);
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX     = 4'(NUM_WRITES - 1);
  state_t       state;
  logic [16:0]  cnt;
  logic [3:0]   idx;
  logic         ok;
  codec_entry_t entry;
  logic         fault_seen;
  logic         wait_exit;
`ifdef CODEC_CONFIG_RETRY_EN
  localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);
  logic [7:0] retries;
`endif
  mod_codec_config_rom u_rom (
    .i_index(idx),
    .o_entry(entry)
  );
  assign o_i2c_addr = I2C_ADDR;
  assign o_i2c_rnw  = 1'b0;
  // Fault codes left over from the previous transaction are masked until the blanking window expires
  assign fault_seen = cnt >= BLANK && i_i2c_fault != 4'hf && i_i2c_fault != 4'h0;
  assign wait_exit  = i_i2c_done || fault_seen || cnt >= TIMEOUT_LAST;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      ok             <= 1'b0;
      o_i2c_register <= '0;
      o_i2c_data     <= '0;
      o_i2c_nrst     <= 1'b0;
      o_busy         <= 1'b0;
      o_config_done  <= 1'b0;
      o_config_error <= 1'b0;
      o_fail_index   <= '0;
`ifdef CODEC_CONFIG_RETRY_EN
      retries        <= '0;
`endif
    end else begin
      cnt <= (&cnt) ? cnt : cnt + 17'd1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (i_start) begin
          state          <= S_LOAD;
          cnt            <= '0;
          idx            <= '0;
          o_busy         <= 1'b1;
          o_config_done  <= 1'b0;
          o_config_error <= 1'b0;
          o_fail_index   <= '0;
`ifdef CODEC_CONFIG_RETRY_EN
          retries        <= '0;
`endif
        end
        S_LOAD: begin
          o_i2c_register <= entry.reg_addr;
          o_i2c_data     <= entry.data;
          o_i2c_nrst     <= 1'b0;
          state          <= S_PULSE;
          cnt            <= '0;
        end
        S_PULSE: if (cnt >= PULSE_LAST) begin
          o_i2c_nrst <= 1'b1;
          state      <= S_WAIT_DONE;
          cnt        <= '0;
        end
        S_WAIT_DONE: if (wait_exit) begin
          ok    <= i_i2c_done && i_i2c_fault == 4'hf;
          state <= S_CHECK;
          cnt   <= '0;
        end
        S_CHECK: begin
          cnt <= '0;
          if (ok && idx == LAST_IDX) begin
            state         <= S_DONE;
            o_busy        <= 1'b0;
            o_config_done <= 1'b1;
          end else if (ok) begin
            idx   <= idx + 4'd1;
            state <= S_LOAD;
`ifdef CODEC_CONFIG_RETRY_EN
            retries <= '0;
          end else if (retries < MAX_R) begin
            retries <= retries + 8'd1;
            state   <= S_LOAD;
`endif
          end else begin
            state          <= S_ERROR;
            o_busy         <= 1'b0;
            o_config_error <= 1'b1;
            o_fail_index   <= idx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
